// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: light encoding,
// phase codes and default phase durations (in one-second ticks).
package traffic_pkg;

  // Two-bit lamp drive value, one per light head.
  typedef enum logic [1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_DARK   = 2'b10,
    LIGHT_RED    = 2'b11
  } light_e;

  // Sequencer phase codes, exported as-is on the phase output.
  typedef enum logic [2:0] {
    PH_ALL_RED   = 3'd0,
    PH_LT_GREEN  = 3'd1,
    PH_LT_YELLOW = 3'd2,
    PH_TH_GREEN  = 3'd3,
    PH_TH_YELLOW = 3'd4,
    PH_FLASH     = 3'd5
  } phase_e;

  localparam int unsigned DEF_NUM_DIR    = 2;
  localparam int unsigned DEF_TICK_DIV   = 12000000;
  localparam int unsigned DEF_GREEN_SEC  = 8;
  localparam int unsigned DEF_YELLOW_SEC = 2;
  localparam int unsigned DEF_ALLRED_SEC = 1;
  localparam int unsigned DEF_LT_SEC     = 4;

  // Value loaded into the remain counter when a phase of 'sec' ticks starts.
  function automatic logic [7:0] dur_m1(input int unsigned sec);
    return 8'(sec - 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles. The count
// only advances while ena is high, so a low ena freezes the tick phase.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Terminal count is only reported while running, so tick stays low when frozen.
  assign tick = ena && (count_q == LAST);

  // Next count: wrap at terminal count, hold while disabled.
  always_comb begin
    count_d = count_q;
    if (ena) begin
      if (tick) count_d = '0;
      else      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase sequencer with per-approach protected left-turn
// demand, night flashing mode and registered lamp outputs. Every state
// change happens on a prescaler tick; the lamps follow one cycle later.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR    = DEF_NUM_DIR,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned GREEN_SEC  = DEF_GREEN_SEC,
  parameter int unsigned YELLOW_SEC = DEF_YELLOW_SEC,
  parameter int unsigned ALLRED_SEC = DEF_ALLRED_SEC,
  parameter int unsigned LT_SEC     = DEF_LT_SEC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_DIR-1:0]   lt_req,
  input  logic                 flash_mode,
  output logic [2*NUM_DIR-1:0] th_light,
  output logic [2*NUM_DIR-1:0] lt_light,
  output logic [1:0]           cur_dir,
  output logic [2:0]           phase,
  output logic [7:0]           remain,
  output logic                 tick
);

  localparam logic [7:0] LOAD_GREEN  = dur_m1(GREEN_SEC);
  localparam logic [7:0] LOAD_YELLOW = dur_m1(YELLOW_SEC);
  localparam logic [7:0] LOAD_ALLRED = dur_m1(ALLRED_SEC);
  localparam logic [7:0] LOAD_LT     = dur_m1(LT_SEC);
  localparam logic [1:0] LAST_DIR    = 2'(NUM_DIR - 1);

  phase_e               phase_q, phase_d;
  logic [1:0]           dir_q, dir_d;
  logic [7:0]           remain_q, remain_d;
  logic [NUM_DIR-1:0]   pend_q, pend_d;
  logic                 flash_dark_q, flash_dark_d;
  logic [2*NUM_DIR-1:0] th_q, th_d;
  logic [2*NUM_DIR-1:0] lt_q, lt_d;
  logic [NUM_DIR-1:0]   dir_oh;
  logic                 pend_hit;
  logic                 lt_grant;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .tick (tick)
  );

  // One-hot of the served approach, used to look up and clear its demand.
  always_comb begin
    dir_oh = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      dir_oh[i] = (dir_q == 2'(i));
    end
  end

  assign pend_hit = |(pend_q & dir_oh);

  // Phase sequencer: flash entry/exit takes priority, otherwise count down
  // the current phase and step to the next one when it expires.
  always_comb begin
    phase_d      = phase_q;
    dir_d        = dir_q;
    remain_d     = remain_q;
    flash_dark_d = flash_dark_q;
    lt_grant     = 1'b0;
    if (tick) begin
      if (phase_q == PH_FLASH) begin
        if (flash_mode) begin
          flash_dark_d = ~flash_dark_q;
        end else begin
          phase_d      = PH_ALL_RED;
          remain_d     = LOAD_ALLRED;
          flash_dark_d = 1'b0;
        end
      end else if (flash_mode) begin
        phase_d      = PH_FLASH;
        remain_d     = 8'd0;
        flash_dark_d = 1'b0;
      end else if (remain_q != 8'd0) begin
        remain_d = remain_q - 8'd1;
      end else begin
        unique case (phase_q)
          PH_ALL_RED: begin
            if (pend_hit) begin
              phase_d  = PH_LT_GREEN;
              remain_d = LOAD_LT;
              lt_grant = 1'b1;
            end else begin
              phase_d  = PH_TH_GREEN;
              remain_d = LOAD_GREEN;
            end
          end
          PH_LT_GREEN: begin
            phase_d  = PH_LT_YELLOW;
            remain_d = LOAD_YELLOW;
          end
          PH_LT_YELLOW: begin
            phase_d  = PH_TH_GREEN;
            remain_d = LOAD_GREEN;
          end
          PH_TH_GREEN: begin
            phase_d  = PH_TH_YELLOW;
            remain_d = LOAD_YELLOW;
          end
          PH_TH_YELLOW: begin
            phase_d  = PH_ALL_RED;
            remain_d = LOAD_ALLRED;
            dir_d    = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;
          end
          default: begin
            phase_d  = PH_ALL_RED;
            remain_d = LOAD_ALLRED;
          end
        endcase
      end
    end
  end

  // Sticky left-turn demand: requests set it at any time (even frozen), and
  // the grant clears the served bit, winning over a same-cycle request.
  always_comb begin
    pend_d = pend_q | lt_req;
    if (lt_grant) pend_d = pend_d & ~dir_oh;
  end

  // Lamp decode from the next state so the registered lamps line up with it.
  always_comb begin
    th_d = '0;
    lt_d = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      th_d[2*i +: 2] = LIGHT_RED;
      lt_d[2*i +: 2] = LIGHT_RED;
      if (phase_d == PH_FLASH) begin
        if (flash_dark_d) begin
          th_d[2*i +: 2] = LIGHT_DARK;
          lt_d[2*i +: 2] = LIGHT_DARK;
        end
      end else if (dir_d == 2'(i)) begin
        case (phase_d)
          PH_LT_GREEN:  lt_d[2*i +: 2] = LIGHT_GREEN;
          PH_LT_YELLOW: lt_d[2*i +: 2] = LIGHT_YELLOW;
          PH_TH_GREEN:  th_d[2*i +: 2] = LIGHT_GREEN;
          PH_TH_YELLOW: th_d[2*i +: 2] = LIGHT_YELLOW;
          default: ;
        endcase
      end
    end
  end

  // Sequencer state, demand latches and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_ALL_RED;
      dir_q        <= 2'd0;
      remain_q     <= LOAD_ALLRED;
      pend_q       <= '0;
      flash_dark_q <= 1'b0;
      th_q         <= '1;
      lt_q         <= '1;
    end else begin
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      remain_q     <= remain_d;
      pend_q       <= pend_d;
      flash_dark_q <= flash_dark_d;
      th_q         <= th_d;
      lt_q         <= lt_d;
    end
  end

  assign th_light = th_q;
  assign lt_light = lt_q;
  assign cur_dir  = dir_q;
  assign phase    = phase_q;
  assign remain   = remain_q;

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 2, meaning number of approaches served round-robin; legal range 2..4.
REQ-002 SHALL have parameter TICK_DIV, default 12000000, meaning clk cycles per one-second tick; minimum 2.
REQ-003 SHALL have parameters GREEN_SEC=8, YELLOW_SEC=2, ALLRED_SEC=1 and LT_SEC=4, meaning phase durations in ticks; legal range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ena  input  1  high = run; low = freeze all state.
REQ-007 SHALL have port lt_req  input  NUM_DIR  per-approach left-turn demand, level or pulse.
REQ-008 SHALL have port flash_mode  input  1  high = night flashing-red mode.
REQ-009 SHALL have port th_light  output  2*NUM_DIR  through light per approach, 2 bits each, approach i at [2i+1:2i].
REQ-010 SHALL have port lt_light  output  2*NUM_DIR  left-turn light per approach, same packing.
REQ-011 SHALL have port cur_dir  output  2  index of the approach currently served.
REQ-012 SHALL have port phase  output  3  current phase state code.
REQ-013 SHALL have port remain  output  8  ticks remaining in the current phase.
REQ-014 SHALL have port tick  output  1  one-cycle pulse at each prescaler terminal count.

Function
REQ-015 SHALL encode light values as 2'b00 green, 2'b01 yellow, 2'b11 red, 2'b10 dark.
REQ-016 SHALL run the prescaler 0..TICK_DIV-1 while ena is high, with tick high in the cycle count == TICK_DIV-1 and the count wrapping to 0.
REQ-017 SHALL implement phases ALL_RED(0), LT_GREEN(1), LT_YELLOW(2), TH_GREEN(3), TH_YELLOW(4) and FLASH(5).
REQ-018 SHALL, on entering any phase, load remain with that phase's duration-1.
REQ-019 SHALL decrement remain on each tick, and SHALL transition on a tick when remain == 0.
REQ-020 SHALL take transitions in this order:
  - ALL_RED -> LT_GREEN if pend[cur_dir] is set, else TH_GREEN;
  - LT_GREEN -> LT_YELLOW -> TH_GREEN -> TH_YELLOW -> ALL_RED;
  - cur_dir advances on TH_YELLOW -> ALL_RED, wrapping NUM_DIR-1 -> 0.
REQ-021 SHALL hold a sticky pend bit per approach:
  - set by lt_req[i];
  - cleared in the cycle approach i enters LT_GREEN;
  - clear wins over a simultaneous set for the same approach.
REQ-022 SHALL drive only the served approach's lights away from red:
  - LT_GREEN: lt green, th red;
  - LT_YELLOW: lt yellow, th red;
  - TH_GREEN: th green, lt red;
  - TH_YELLOW: th yellow, lt red;
  - all other approaches and all other phases: red.
REQ-023 SHALL register all outputs except tick, so lights change in the cycle after the tick that causes the transition.
REQ-024 SHALL enter FLASH from any phase on the first tick with flash_mode high, loading remain with 0.
REQ-025 SHALL, in FLASH, toggle every th/lt light between red and dark on each tick, starting red.
REQ-026 SHALL leave FLASH on the first tick with flash_mode low, entering ALL_RED with cur_dir unchanged and pend preserved.
REQ-027 SHALL, while ena is low, hold prescaler, phase, remain, cur_dir and outputs, keep tick low, and still allow pend to set.
REQ-028 SHALL keep cur_dir < NUM_DIR at all times.

Reset
REQ-029 SHALL, while rst_n is low, hold the prescaler at 0, phase at ALL_RED, remain at ALLRED_SEC-1, cur_dir at 0, pend at 0, every light at 2'b11 and tick at 0.
REQ-030 SHALL abandon any phase mid-operation on reset assertion, and SHALL restart from ALL_RED on the first clk edge after release.

Structure
REQ-031 SHALL take the light encoding enum, the phase enum and the default duration constants from shared package traffic_pkg.
REQ-032 SHALL place the prescaler in sub-module tick_prescaler, with parameter TICK_DIV and ports clk, rst_n, ena and tick.
REQ-033 SHALL implement the sequencer, pend latches and light decode in traffic_phase_ctrl itself.

Verification (NUM_DIR=2, TICK_DIV=4, GREEN=3, YELLOW=1, ALLRED=1, LT=2)
REQ-034 SHALL verify: reset release, no requests -> ALL_RED 4 cycles, dir0 TH_GREEN 12 cycles, TH_YELLOW 4, ALL_RED 4, then dir1 TH_GREEN; th_light = 2'b00 at [1:0] only during dir0 green.
REQ-035 SHALL verify: 1-cycle pulse lt_req = 2'b10 during dir0 TH_GREEN -> dir1 gets LT_GREEN for 8 cycles and LT_YELLOW for 4, then TH_GREEN; pend[1] clears on LT_GREEN entry.
REQ-036 SHALL verify: lt_req[0] held high across dir0 LT_GREEN entry -> pend[0] stays clear only for the entry cycle, then sets again and is served on dir0's next turn.
REQ-037 SHALL verify: flash_mode high mid TH_GREEN -> phase = 5 after the next tick, all lights alternate 11/10 per tick; flash_mode low -> ALL_RED with the same cur_dir.
REQ-038 SHALL verify: ena low for 10 cycles mid TH_GREEN with remain = 1 -> remain, lights and prescaler frozen, tick low; on resume, timing continues exactly where it stopped.
REQ-039 SHALL verify: rst_n low mid LT_YELLOW on dir1 -> all lights 11 immediately (asynchronous), cur_dir = 0 and pend = 0 after release.
